// File: rtl/clusterv_sram_target.sv
// Single-ported word memory shared by an OpenRAM-style RW port and a Wishbone
// classic backdoor. The SRAM port always wins; Wishbone requests wait for a free edge.
module clusterv_sram_target #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sram_csb,
    input  logic                    sram_web,
    input  logic [DATA_WIDTH/8-1:0] sram_wmask,
    input  logic [ADDR_WIDTH-1:0]   sram_addr,
    input  logic [DATA_WIDTH-1:0]   sram_dat_w,
    output logic [DATA_WIDTH-1:0]   sram_dat_r,
    input  logic [31:0]             t_adr,
    input  logic [DATA_WIDTH-1:0]   t_dat_w,
    output logic [DATA_WIDTH-1:0]   t_dat_r,
    input  logic                    t_cyc,
    input  logic                    t_stb,
    input  logic                    t_we,
    input  logic [DATA_WIDTH/8-1:0] t_sel,
    output logic                    t_ack
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] sram_dat_r_q;
    logic [DATA_WIDTH-1:0] t_dat_r_q;

    logic [ADDR_WIDTH-1:0] wb_index;
    logic                  sram_rd, sram_wr;
    logic                  wb_go, wb_rd, wb_wr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LANES-1:0]      lane_we;
    logic [DATA_WIDTH-1:0] wr_data;

    // Byte-lane and word-select bits of t_adr that the word index does not use.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, t_adr[31:ADDR_WIDTH+2], t_adr[1:0]};

    assign wb_index = t_adr[ADDR_WIDTH+1:2];
    assign sram_rd  = !sram_csb && sram_web;
    assign sram_wr  = !sram_csb && !sram_web;

    // A Wishbone access only happens on an edge the SRAM port leaves idle.
    assign wb_go = (state_q == ST_IDLE) && t_cyc && t_stb && sram_csb;
    assign wb_rd = wb_go && !t_we;
    assign wb_wr = wb_go && t_we;

    assign wr_addr = sram_wr ? sram_addr  : wb_index;
    assign wr_data = sram_wr ? sram_dat_w : t_dat_w;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_we[gi] = sram_wr ? sram_wmask[gi] : (wb_wr && t_sel[gi]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sram_dat_r_q <= '0;
            t_dat_r_q    <= '0;
        end else begin
            if (sram_rd) begin
                sram_dat_r_q <= mem[sram_addr];
            end
            if (wb_rd) begin
                t_dat_r_q <= mem[wb_index];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (wb_go) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign t_ack      = (state_q == ST_ACK);
    assign sram_dat_r = sram_dat_r_q;
    assign t_dat_r    = t_dat_r_q;

endmodule

// File: tb/tb_clusterv_sram_target.sv
// Directed bench for clusterv_sram_target: SRAM-port reads/writes, byte masks,
// Wishbone access, port contention, back-to-back transfers and mid-transfer reset.
module tb_clusterv_sram_target;

    logic        clock;
    logic        reset;
    logic        sram_csb;
    logic        sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_dat_w;
    logic [31:0] sram_dat_r;
    logic [31:0] t_adr;
    logic [31:0] t_dat_w;
    logic [31:0] t_dat_r;
    logic        t_cyc, t_stb, t_we;
    logic [3:0]  t_sel;
    logic        t_ack;

    int checks_total = 0;
    int checks_passed = 0;

    clusterv_sram_target #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_dat_w (sram_dat_w),
        .sram_dat_r (sram_dat_r),
        .t_adr      (t_adr),
        .t_dat_w    (t_dat_w),
        .t_dat_r    (t_dat_r),
        .t_cyc      (t_cyc),
        .t_stb      (t_stb),
        .t_we       (t_we),
        .t_sel      (t_sel),
        .t_ack      (t_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sram_write(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        sram_csb = 1'b0; sram_web = 1'b0; sram_addr = a; sram_wmask = m; sram_dat_w = d;
        tick();
        sram_csb = 1'b1; sram_web = 1'b1;
    endtask

    task automatic sram_read(input logic [7:0] a);
        sram_csb = 1'b0; sram_web = 1'b1; sram_addr = a;
        tick();
        sram_csb = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        sram_csb = 1'b1; sram_web = 1'b1; sram_wmask = 4'h0; sram_addr = 8'h00; sram_dat_w = '0;
        t_adr = '0; t_dat_w = '0; t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0; t_sel = 4'h0;
        #1;
        check("rst_ack", {31'b0, t_ack}, 32'h0);
        check("rst_sram_dat_r", sram_dat_r, 32'h0);
        check("rst_t_dat_r", t_dat_r, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Full-word SRAM write then read
        sram_csb = 1'b0; sram_web = 1'b0; sram_addr = 8'h05; sram_wmask = 4'hF; sram_dat_w = 32'hDEADBEEF;
        tick();
        check("write_no_rdata", sram_dat_r, 32'h0);
        sram_web = 1'b1;
        tick();
        sram_csb = 1'b1;
        check("sram_rd_05", sram_dat_r, 32'hDEADBEEF);
        tick();
        check("sram_rd_hold", sram_dat_r, 32'hDEADBEEF);

        // Byte mask
        sram_write(8'h10, 4'hF, 32'h11223344);
        sram_write(8'h10, 4'h5, 32'hAABBCCDD);
        sram_read(8'h10);
        check("byte_mask", sram_dat_r, 32'h11BB33DD);

        // Wishbone write, then SRAM read of the same word
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_adr = 32'h20; t_sel = 4'hF; t_dat_w = 32'hCAFEF00D;
        tick();
        check("wb_wr_ack", {31'b0, t_ack}, 32'h1);
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        sram_read(8'h08);
        check("wb_wr_ack_drop", {31'b0, t_ack}, 32'h0);
        check("sram_rd_08", sram_dat_r, 32'hCAFEF00D);
        check("t_dat_r_unchanged", t_dat_r, 32'h0);

        // Wishbone partial write with t_sel, read back over Wishbone
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_adr = 32'h20; t_sel = 4'h2; t_dat_w = 32'h0000EE00;
        tick();
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        tick();
        t_cyc = 1'b1; t_stb = 1'b1; t_adr = 32'h20;
        tick();
        check("wb_sel_ack", {31'b0, t_ack}, 32'h1);
        check("wb_sel_data", t_dat_r, 32'hCAFEEE0D);
        t_cyc = 1'b0; t_stb = 1'b0;
        tick();

        // Contention: SRAM port busy for 5 cycles while a Wishbone read waits
        sram_write(8'h09, 4'hF, 32'h12345678);
        sram_csb = 1'b0; sram_web = 1'b1; sram_addr = 8'h05;
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h24;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("contend_ack_%0d", i), {31'b0, t_ack}, 32'h0);
        end
        sram_csb = 1'b1;
        tick();
        check("contend_ack", {31'b0, t_ack}, 32'h1);
        check("contend_data", t_dat_r, 32'h12345678);
        t_cyc = 1'b0; t_stb = 1'b0;
        tick();
        check("contend_ack_off", {31'b0, t_ack}, 32'h0);

        // Back-to-back reads words 0..3 with cyc/stb held
        for (int i = 0; i < 4; i++) sram_write(i[7:0], 4'hF, 32'hA0000000 + 32'(i));
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t_adr = 32'(i * 4);
            tick();
            check($sformatf("b2b_ack_%0d", i), {31'b0, t_ack}, 32'h1);
            check($sformatf("b2b_data_%0d", i), t_dat_r, 32'hA0000000 + 32'(i));
            tick();
            check($sformatf("b2b_gap_%0d", i), {31'b0, t_ack}, 32'h0);
        end
        t_cyc = 1'b0; t_stb = 1'b0;

        // Strobe dropped during ACK: access still commits
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_adr = 32'h30; t_sel = 4'hF; t_dat_w = 32'h55AA55AA;
        tick();
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        #1;
        check("drop_ack", {31'b0, t_ack}, 32'h1);
        tick();

        // Reset during ACK
        sram_read(8'h05);
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_adr = 32'h34; t_sel = 4'hF; t_dat_w = 32'h0BADCAFE;
        tick();
        check("pre_rst_ack", {31'b0, t_ack}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_ack", {31'b0, t_ack}, 32'h0);
        check("async_rst_sram_dat_r", sram_dat_r, 32'h0);
        check("async_rst_t_dat_r", t_dat_r, 32'h0);
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        reset = 1'b0;
        sram_read(8'h0D);
        check("post_rst_word13", sram_dat_r, 32'h0BADCAFE);
        sram_read(8'h0C);
        check("post_rst_word12", sram_dat_r, 32'h55AA55AA);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/clusterv_sram_target.md
CLUSTERV_SRAM_TARGET -- requirements
Module: clusterv_sram_target

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8, word-address width; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter: DATA_WIDTH, default 32, word width; byte lanes = DATA_WIDTH/8.
REQ-003 Port: clock  input  1  clock; all state updates on posedge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: sram_csb  input  1  OpenRAM RW port chip select, active-low.
REQ-006 Port: sram_web  input  1  write enable, active-low; 1 = read.
REQ-007 Port: sram_wmask  input  DATA_WIDTH/8  byte write mask, active-high, bit i = bits [8i+7:8i].
REQ-008 Port: sram_addr  input  ADDR_WIDTH  word address.
REQ-009 Port: sram_dat_w  input  DATA_WIDTH  write data.
REQ-010 Port: sram_dat_r  output  DATA_WIDTH  registered read data.
REQ-011 Port: t_adr  input  32  Wishbone backdoor byte address; word index = t_adr[ADDR_WIDTH+1:2], other bits ignored.
REQ-012 Port: t_dat_w  input  DATA_WIDTH  Wishbone write data.
REQ-013 Port: t_dat_r  output  DATA_WIDTH  Wishbone read data, registered.
REQ-014 Port: t_cyc, t_stb, t_we  input  1 each  Wishbone classic cycle, strobe, write.
REQ-015 Port: t_sel  input  DATA_WIDTH/8  Wishbone byte select, active-high.
REQ-016 Port: t_ack  output  1  Wishbone acknowledge, single-cycle pulse.

Function
REQ-017 Storage: depth x DATA_WIDTH array; contents not reset, undefined until written.
REQ-018 SRAM port access: sram_csb=0 sampled at posedge, with sram_web=0: each byte lane with sram_wmask[i]=1 written at that edge; lanes with mask 0 unchanged; sram_dat_r unchanged.
REQ-019 SRAM port read: sram_csb=0, sram_web=1 at posedge: sram_dat_r <= mem[sram_addr] at that edge (1-cycle latency, valid from the next cycle and held until the next SRAM-port read).
REQ-020 sram_csb=1 at posedge: no SRAM-port effect; sram_dat_r holds.
REQ-021 SRAM port never stalls, has no wait signal; SRAM port has strict priority over Wishbone.
REQ-022 Wishbone FSM states: IDLE, ACK.
REQ-023 IDLE: t_cyc&t_stb=1 and sram_csb=1 at posedge -> perform access at that edge, go ACK; write: bytes with t_sel[i]=1 written; read: t_dat_r <= mem[word index].
REQ-024 IDLE: t_cyc&t_stb=1 and sram_csb=0 -> no access, remain IDLE (request waits, retried every cycle).
REQ-025 ACK: t_ack=1 for exactly that cycle; next state IDLE unconditionally; t_ack=0 in IDLE.
REQ-026 Back-to-back Wishbone: minimum 2 cycles per transfer (request sample, ack); new request sampled in IDLE after ACK.
REQ-027 t_cyc or t_stb dropped while in ACK: ack still asserted once, access already committed; no abort.
REQ-028 Same-address Wishbone write then SRAM read: SRAM read in cycle after the write edge returns new data; no bypass otherwise needed (accesses never share an edge).
REQ-029 t_dat_r holds last Wishbone read value; unchanged by writes and SRAM-port activity.

Reset
REQ-030 reset=1: FSM -> IDLE, t_ack=0, sram_dat_r=0, t_dat_r=0, asynchronously; memory contents retained.
REQ-031 Reset asserted in ACK: ack suppressed immediately; a write already committed at the prior edge remains in memory.
REQ-032 Reset deasserted: first posedge after deassertion processes inputs normally.

Verification
REQ-033 SRAM write addr 0x05, wmask 0xF, data 0xDEADBEEF; next cycle read addr 0x05 -> sram_dat_r=0xDEADBEEF one cycle after read csb edge.
REQ-034 Byte mask: write 0x11223344 all lanes to 0x10, then write 0xAABBCCDD mask 0x5 -> read returns 0x11BB33DD.
REQ-035 Wishbone write t_adr=0x20 (word 8) sel 0xF data 0xCAFEF00D, sram_csb=1 -> t_ack 1 cycle after request edge; SRAM read word 8 -> 0xCAFEF00D.
REQ-036 Contention: Wishbone read pending while sram_csb=0 for 5 cycles -> t_ack=0 throughout; ack 1 cycle after the first edge with sram_csb=1, t_dat_r correct.
REQ-037 Reset mid-transfer: assert reset during ACK -> t_ack, sram_dat_r, t_dat_r go 0 without clock; previously written word still reads back after reset.
REQ-038 Back-to-back Wishbone reads words 0..3 with cyc/stb held high -> ack every other cycle, data in order.
